// File: rtl/nvdla_cdma_csb_req_bridge.sv
// CSB request bridge into the CDMA single register file; partial writes run as read-modify-write.
// Define NVDLA_CDMA_CSB_STRICT_DECODE_EN to restrict decode to offsets 0x000-0x00C.
module nvdla_cdma_csb_req_bridge (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,
    input  logic        csb2cdma_req_pvld,
    output logic        csb2cdma_req_prdy,
    input  logic [62:0] csb2cdma_req_pd,
    output logic        cdma2csb_resp_valid,
    output logic [33:0] cdma2csb_resp_pd,
    output logic [11:0] reg_offset,
    output logic [31:0] reg_wr_data,
    output logic        reg_wr_en,
    input  logic [31:0] reg_rd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        MERGE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] wdat_q, wdat_d;
    logic        write_q, write_d;
    logic        nposted_q, nposted_d;
    logic [3:0]  wrbe_q, wrbe_d;
    logic        hit_q, hit_d;
    logic [11:0] reg_offset_q, reg_offset_d;
    logic [31:0] reg_wr_data_q, reg_wr_data_d;
    logic        reg_wr_en_q, reg_wr_en_d;
    logic        resp_valid_q, resp_valid_d;
    logic [33:0] resp_pd_q, resp_pd_d;

    logic [21:0] req_addr;
    logic [31:0] req_wdat;
    logic        req_write;
    logic        req_nposted;
    logic [3:0]  req_wrbe;
    logic        req_hit;
    logic [31:0] merged;
    logic        unused_pd_bits;

    assign req_addr    = csb2cdma_req_pd[21:0];
    assign req_wdat    = csb2cdma_req_pd[53:22];
    assign req_write   = csb2cdma_req_pd[54];
    assign req_nposted = csb2cdma_req_pd[55];
    assign req_wrbe    = csb2cdma_req_pd[60:57];
    assign unused_pd_bits = ^{csb2cdma_req_pd[62:61], csb2cdma_req_pd[56]};

    // Byte address bits [23:12] select the window; strict mode also bounds the offset.
    assign req_hit = (req_addr[21:10] == 12'h005)
`ifdef NVDLA_CDMA_CSB_STRICT_DECODE_EN
                     && (req_addr[9:2] == 8'h00)
`endif
                     ;

    always_comb begin
        merged = reg_rd_data;
        for (int i = 0; i < 4; i++) begin
            if (wrbe_q[i]) begin
                merged[8*i +: 8] = wdat_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wdat_d        = wdat_q;
        write_d       = write_q;
        nposted_d     = nposted_q;
        wrbe_d        = wrbe_q;
        hit_d         = hit_q;
        reg_offset_d  = reg_offset_q;
        reg_wr_data_d = reg_wr_data_q;
        reg_wr_en_d   = 1'b0;
        resp_pd_d     = resp_pd_q;
        unique case (state_q)
            IDLE: begin
                if (csb2cdma_req_pvld) begin
                    wdat_d       = req_wdat;
                    write_d      = req_write;
                    nposted_d    = req_nposted;
                    wrbe_d       = req_wrbe;
                    hit_d        = req_hit;
                    reg_offset_d = {req_addr[9:0], 2'b00};
                    // Full-word writes strobe in EXEC, so launch them on acceptance.
                    if (req_write && req_hit && (req_wrbe == 4'hF)) begin
                        reg_wr_en_d   = 1'b1;
                        reg_wr_data_d = req_wdat;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!write_q) begin
                    resp_pd_d = {1'b0, ~hit_q, hit_q ? reg_rd_data : 32'h0};
                    state_d   = RESP;
                end else if (hit_q && (wrbe_q != 4'h0) && (wrbe_q != 4'hF)) begin
                    reg_wr_en_d   = 1'b1;
                    reg_wr_data_d = merged;
                    state_d       = MERGE;
                end else begin
                    resp_pd_d = {1'b1, ~hit_q, 32'h0};
                    state_d   = nposted_q ? RESP : IDLE;
                end
            end
            MERGE: begin
                resp_pd_d = {2'b10, 32'h0};
                state_d   = nposted_q ? RESP : IDLE;
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q       <= IDLE;
            wdat_q        <= 32'h0;
            write_q       <= 1'b0;
            nposted_q     <= 1'b0;
            wrbe_q        <= 4'h0;
            hit_q         <= 1'b0;
            reg_offset_q  <= 12'h0;
            reg_wr_data_q <= 32'h0;
            reg_wr_en_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_pd_q     <= 34'h0;
        end else begin
            state_q       <= state_d;
            wdat_q        <= wdat_d;
            write_q       <= write_d;
            nposted_q     <= nposted_d;
            wrbe_q        <= wrbe_d;
            hit_q         <= hit_d;
            reg_offset_q  <= reg_offset_d;
            reg_wr_data_q <= reg_wr_data_d;
            reg_wr_en_q   <= reg_wr_en_d;
            resp_valid_q  <= resp_valid_d;
            resp_pd_q     <= resp_pd_d;
        end
    end

    assign csb2cdma_req_prdy   = (state_q == IDLE);
    assign cdma2csb_resp_valid = resp_valid_q;
    assign cdma2csb_resp_pd    = resp_pd_q;
    assign reg_offset          = reg_offset_q;
    assign reg_wr_data         = reg_wr_data_q;
    assign reg_wr_en           = reg_wr_en_q;

endmodule

// File: tb/tb_nvdla_cdma_csb_req_bridge.sv
// Bench for nvdla_cdma_csb_req_bridge: timeline model of expected outputs per cycle,
// a small register file behind the DUT, and directed literal checks.
module tb_nvdla_cdma_csb_req_bridge;

    localparam int N = 600;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pvld = 1'b0;
    logic [62:0] pd = '0;
    logic        prdy;
    logic        rv;
    logic [33:0] rpd;
    logic [11:0] off;
    logic [31:0] wdata;
    logic        wen;
    logic [31:0] rdata;

    int cyc = 0;
    int nvec = 0;
    int nfail = 0;
    int next_free = 0;

    bit          exp_prdy [N];
    bit          exp_wen  [N];
    bit          exp_rv   [N];
    bit          chk_off  [N];
    logic [31:0] exp_wd   [N];
    logic [33:0] exp_rpd  [N];
    logic [11:0] exp_off  [N];
    logic [31:0] shadow   [0:1023];
    logic [31:0] mem      [0:1023];

    always #5 clk = ~clk;

    nvdla_cdma_csb_req_bridge dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rstn     (rstn),
        .csb2cdma_req_pvld   (pvld),
        .csb2cdma_req_prdy   (prdy),
        .csb2cdma_req_pd     (pd),
        .cdma2csb_resp_valid (rv),
        .cdma2csb_resp_pd    (rpd),
        .reg_offset          (off),
        .reg_wr_data         (wdata),
        .reg_wr_en           (wen),
        .reg_rd_data         (rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'hDEAD0000;
            2:       return 32'h0003000F;
            3:       return 32'h11223344;
            4:       return 32'hA5A50004;
            default: return 32'h01000000 + 32'(i);
        endcase
    endfunction

    assign rdata = mem[off[11:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (wen) begin
            mem[off[11:2]] <= wdata;
        end
    end

    function automatic logic [62:0] mkpd(input logic [21:0] a, input logic [31:0] wd,
                                         input logic w, input logic np, input logic [3:0] be);
        return {2'b10, be, 1'b1, np, w, wd, a};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Request presented from period p; returns the period in which it executes.
    task automatic predict(input int p, input logic [21:0] a, input logic [31:0] wd,
                           input logic w, input logic np, input logic [3:0] be, output int t);
        logic [23:0] ba;
        logic [11:0] o;
        logic        hit;
        logic [31:0] m;
        int          e;
        int          done;
        ba  = {a, 2'b00};
        o   = ba[11:0];
        hit = (ba[23:12] == 12'h005);
`ifdef NVDLA_CDMA_CSB_STRICT_DECODE_EN
        hit = hit && (o < 12'h010);
`endif
        e = ((p > next_free) ? p : next_free) + 1;
        t = e;
        chk_off[e] = 1'b1;
        exp_off[e] = o;
        if (!w) begin
            exp_rv[e+1]  = 1'b1;
            exp_rpd[e+1] = {1'b0, !hit, hit ? shadow[o[11:2]] : 32'h0};
            done = e + 2;
        end else if (hit && be == 4'hF) begin
            exp_wen[e] = 1'b1;
            exp_wd[e]  = wd;
            shadow[o[11:2]] = wd;
            if (np) begin
                exp_rv[e+1]  = 1'b1;
                exp_rpd[e+1] = {2'b10, 32'h0};
            end
            done = np ? e + 2 : e + 1;
        end else if (hit && be != 4'h0) begin
            m = shadow[o[11:2]];
            for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
            exp_wen[e+1] = 1'b1;
            exp_wd[e+1]  = m;
            chk_off[e+1] = 1'b1;
            exp_off[e+1] = o;
            shadow[o[11:2]] = m;
            if (np) begin
                exp_rv[e+2]  = 1'b1;
                exp_rpd[e+2] = {2'b10, 32'h0};
            end
            done = np ? e + 3 : e + 2;
        end else begin
            if (np) begin
                exp_rv[e+1]  = 1'b1;
                exp_rpd[e+1] = {1'b1, !hit, 32'h0};
            end
            done = np ? e + 2 : e + 1;
        end
        for (int c = e; c < done; c++) exp_prdy[c] = 1'b0;
        next_free = done;
    endtask

    task automatic model_reset(input int c);
        for (int i = c; i < N; i++) begin
            exp_prdy[i] = 1'b1;
            exp_wen[i]  = 1'b0;
            exp_rv[i]   = 1'b0;
            chk_off[i]  = 1'b0;
        end
        next_free = c + 1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic send(input logic [21:0] a, input logic [31:0] wd, input logic w,
                        input logic np, input logic [3:0] be, input bit hold, output int t);
        pvld = 1'b1;
        pd   = mkpd(a, wd, w, np, be);
        predict(cyc, a, wd, w, np, be, t);
        goto(t);
        #1;
        if (!hold) pvld = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        int t1;
        int t2;
        logic [31:0] saved;
        for (int i = 0; i < N; i++) begin
            exp_prdy[i] = 1'b1;
            exp_wen[i]  = 1'b0;
            exp_rv[i]   = 1'b0;
            chk_off[i]  = 1'b0;
            exp_wd[i]   = '0;
            exp_rpd[i]  = '0;
            exp_off[i]  = '0;
        end
        for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);

        fork
            forever begin
                @(negedge clk);
                if (cyc < N) begin
                    chk("prdy", 64'(prdy), 64'(exp_prdy[cyc]));
                    chk("wr_en", 64'(wen), 64'(exp_wen[cyc]));
                    if (exp_wen[cyc]) chk("wr_data", 64'(wdata), 64'(exp_wd[cyc]));
                    chk("resp_valid", 64'(rv), 64'(exp_rv[cyc]));
                    if (exp_rv[cyc]) chk("resp_pd", 64'(rpd), 64'(exp_rpd[cyc]));
                    if (chk_off[cyc]) chk("offset", 64'(off), 64'(exp_off[cyc]));
                end
            end
        join_none

        goto(3);
        chk("rst_prdy", 64'(prdy), 64'(1));
        chk("rst_rv", 64'(rv), 64'(0));
        chk("rst_rpd", 64'(rpd), 64'(0));
        chk("rst_off", 64'(off), 64'(0));
        chk("rst_wdata", 64'(wdata), 64'(0));
        chk("rst_wen", 64'(wen), 64'(0));
        #1 rstn = 1'b1;

        send(22'h1402, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, t);
        chk("rd_off", 64'(off), 64'(12'h008));
        goto(t + 1);
        chk("rd_rv", 64'(rv), 64'(1));
        chk("rd_pd", 64'(rpd), 64'(34'h0_0003000F));

        send(22'h1401, 32'h1, 1'b1, 1'b0, 4'hF, 1'b0, t);
        chk("pw_en", 64'(wen), 64'(1));
        chk("pw_off", 64'(off), 64'(12'h004));
        chk("pw_data", 64'(wdata), 64'(32'h1));
        goto(t + 1);
        chk("pw_prdy", 64'(prdy), 64'(1));
        chk("pw_norv", 64'(rv), 64'(0));

        send(22'h1402, 32'h00050000, 1'b1, 1'b1, 4'b0100, 1'b0, t);
        chk("pp_exec_noen", 64'(wen), 64'(0));
        goto(t + 1);
        chk("pp_en", 64'(wen), 64'(1));
        chk("pp_data", 64'(wdata), 64'(32'h0005000F));
        goto(t + 2);
        chk("pp_rv", 64'(rv), 64'(1));
        chk("pp_pd", 64'(rpd), 64'(34'h2_00000000));

        send(22'h1800, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, t);
        goto(t + 1);
        chk("oow_rd_pd", 64'(rpd), 64'(34'h1_00000000));

        send(22'h1404, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, t);
        goto(t + 1);
`ifdef NVDLA_CDMA_CSB_STRICT_DECODE_EN
        chk("rd5010_pd", 64'(rpd), 64'(34'h1_00000000));
`else
        chk("rd5010_pd", 64'(rpd), 64'(34'h0_A5A50004));
`endif

        send(22'h2401, 32'hFFFFFFFF, 1'b1, 1'b1, 4'hF, 1'b0, t);
        chk("oow_wr_noen", 64'(wen), 64'(0));
        goto(t + 1);
        chk("oow_wr_pd", 64'(rpd), 64'(34'h3_00000000));

        send(22'h1400, 32'hFFFFFFFF, 1'b1, 1'b1, 4'h0, 1'b0, t);
        chk("be0_noen", 64'(wen), 64'(0));
        goto(t + 1);
        chk("be0_pd", 64'(rpd), 64'(34'h2_00000000));

        send(22'h1403, 32'hAABBCCDD, 1'b1, 1'b0, 4'b1001, 1'b0, t);
        goto(t + 1);
        chk("pp2_en", 64'(wen), 64'(1));
        chk("pp2_data", 64'(wdata), 64'(32'hAA2233DD));

        send(22'h1403, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, t1);
        pd = mkpd(22'h1401, 32'h0, 1'b0, 1'b0, 4'h0);
        predict(cyc, 22'h1401, 32'h0, 1'b0, 1'b0, 4'h0, t2);
        chk("b2b_gap", 64'(t2 - t1), 64'(3));
        goto(t1 + 1);
        chk("b2b_prdy_lo", 64'(prdy), 64'(0));
        chk("b2b_pd1", 64'(rpd), 64'(34'h0_AA2233DD));
        goto(t2);
        #1 pvld = 1'b0;
        goto(t2 + 1);
        chk("b2b_pd2", 64'(rpd), 64'(34'h0_00000001));

        send(22'h1400, 32'h00000055, 1'b1, 1'b0, 4'hF, 1'b1, t1);
        pd = mkpd(22'h1403, 32'h000000AA, 1'b1, 1'b0, 4'hF);
        predict(cyc, 22'h1403, 32'h000000AA, 1'b1, 1'b0, 4'hF, t2);
        chk("pw_gap", 64'(t2 - t1), 64'(2));
        goto(t2);
        chk("pw2_en", 64'(wen), 64'(1));
        chk("pw2_off", 64'(off), 64'(12'h00C));
        #1 pvld = 1'b0;

        saved = shadow[2];
        send(22'h1402, 32'hFFFFFFFF, 1'b1, 1'b1, 4'b0001, 1'b0, t);
        shadow[2] = saved;
        model_reset(t + 1);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        chk("mrst_wen", 64'(wen), 64'(0));
        chk("mrst_rv", 64'(rv), 64'(0));
        @(negedge clk);
        chk("mrst_prdy", 64'(prdy), 64'(1));
        #1 rstn = 1'b1;
        goto(t + 3);
        chk("post_prdy", 64'(prdy), 64'(1));
        chk("post_off", 64'(off), 64'(0));
        chk("post_wdata", 64'(wdata), 64'(0));
        chk("post_rpd", 64'(rpd), 64'(0));
        chk("post_wen", 64'(wen), 64'(0));

        send(22'h1402, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, t);
        goto(t + 1);
        chk("norst_wr_pd", 64'(rpd), 64'(34'h0_0005000F));

        send(22'h1400, 32'h12345678, 1'b1, 1'b1, 4'hF, 1'b0, t);
        chk("npw_data", 64'(wdata), 64'(32'h12345678));
        goto(t + 1);
        chk("npw_pd", 64'(rpd), 64'(34'h2_00000000));

        goto(t + 4);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/nvdla_cdma_csb_req_bridge.md
# nvdla_cdma_csb_req_bridge

CSB-side initiator for the CDMA single register group: accepts one CSB request packet at a time, drives the flat register interface (offset, write data, write strobe, combinational read data) of the CDMA single register file, and returns a CSB response packet. Partial-byte-enable writes are executed as a read-modify-write over two register-interface cycles. It sits between the CSB fabric and the single register file inside CDMA.

## Interface
- No parameters.
- nvdla_core_clk  input  1  core clock; all state rises on posedge.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- csb2cdma_req_pvld  input  1  request valid.
- csb2cdma_req_prdy  output  1  request ready; high only in IDLE.
- csb2cdma_req_pd  input  63  [21:0] word addr, [53:22] wdat, [54] write, [55] nposted, [56] srcpriv (ignored), [60:57] wrbe, [62:61] level (ignored).
- cdma2csb_resp_valid  output  1  one-cycle response pulse, no backpressure.
- cdma2csb_resp_pd  output  34  [31:0] data, [32] error, [33] type (0 read, 1 write).
- reg_offset  output  12  register byte offset.
- reg_wr_data  output  32  register write data.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_rd_data  input  32  combinational read data for current reg_offset.

## Operation
- Byte address = {addr, 2'b00} (24 bits). In-window iff byte address [23:12] == 12'h005; reg_offset = byte address [11:0] = {addr[9:0], 2'b00}.
- States: IDLE, EXEC, MERGE, RESP. Reset state IDLE.
- IDLE: prdy=1. On pvld&prdy, capture addr, wdat, write, nposted, wrbe; go EXEC.
- EXEC: reg_offset driven from captured address.
  - Read: capture reg_rd_data (0 if out-of-window) into response data; go RESP.
  - Write, in-window, wrbe==4'hF: reg_wr_en=1, reg_wr_data=wdat; go RESP if nposted else IDLE.
  - Write, in-window, wrbe in 1..14: capture reg_rd_data; go MERGE.
  - Write, wrbe==0 or out-of-window: no strobe; go RESP if nposted else IDLE.
- MERGE: reg_wr_en=1, reg_wr_data byte i = wrbe[i] ? wdat byte i : captured byte i; go RESP if nposted else IDLE.
- RESP: resp_valid=1 for one cycle; go IDLE.
- Response pd: read {1'b0, err, rdat}; write {1'b1, err, 32'h0}. err=1 iff out-of-window (or strict-decode miss, see Configuration).
- Out-of-window writes never assert reg_wr_en; posted writes produce no response regardless of err.

## Timing
- Reset values: prdy=1 (IDLE), resp_valid=0, resp_pd=0, reg_offset=0, reg_wr_data=0, reg_wr_en=0; all registered except prdy (decoded from state).
- Accept at edge T: EXEC during cycle T+1; read/full-write/no-op response valid in cycle T+2; partial-write strobe in T+2, response T+3.
- reg_offset and reg_wr_data hold last value outside EXEC/MERGE; reg_wr_en is never high for two consecutive cycles.
- Max throughput: one request per 2 cycles (posted full write), 3 (read/nposted full write), 4 (nposted partial write).
- pvld while not IDLE is ignored (prdy=0); requester must hold pd until acceptance.
- Reset mid-operation: state returns to IDLE immediately, pending strobe/response discarded, no write issued after reset deassertion.

## Configuration
- NVDLA_CDMA_CSB_STRICT_DECODE_EN defined: in-window offsets other than 0x000, 0x004, 0x008, 0x00C are treated as out-of-window (err=1, read data 0, no strobe).
- Undefined: any in-window offset is passed to the register file; err only for out-of-window addresses.

## Test plan
- Read addr 22'h1402 (byte 0x5008) with reg_rd_data=32'h0003000F -> reg_offset 0x008 in T+1, resp_pd 34'h0_0003000F valid in T+2.
- Posted write addr 22'h1401, wdat 32'h1, wrbe 4'hF -> reg_wr_en one cycle in T+1 with reg_offset 0x004, data 32'h1; no resp_valid; prdy high in T+2.
- Non-posted partial write wrbe 4'b0100, wdat 32'h00050000, reg_rd_data 32'h0003000F -> reg_wr_en in T+2 with data 32'h0005000F; resp_pd {1,0,32'h0} in T+3.
- Read byte address 0x6000 -> no strobe, resp_pd {0,1,32'h0}; read 0x5010 -> err=1 only with NVDLA_CDMA_CSB_STRICT_DECODE_EN.
- Back-to-back pvld held high with two reads -> second accepted only after RESP (prdy low in EXEC/RESP), two responses 3 cycles apart.
- Assert nvdla_core_rstn low during MERGE -> no reg_wr_en, no resp_valid; after release prdy=1 and outputs at reset values.
